// File: rtl/hex_display_pkg.sv
// Shared seven-segment constants and polarity helper for the HEX display driver.
// Codes are active-low, bit 6 = g ... bit 0 = a.
package hex_display_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK_AL = 7'h7F;

    // Converts an active-low code to the board's pin polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] code, input logic active_low);
        return active_low ? code : ~code;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment code.
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    always_comb begin
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            4'hF:    code = SEG_F;
            default: code = SEG_BLANK_AL;
        endcase
    end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit static seven-segment driver: latched value, leading-zero blanking,
// per-digit blink and global enable, with registered segment outputs.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    enable,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int              HALF     = CLK_HZ / (2 * BLINK_HZ);
    localparam int              PRE_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF - 1);
    localparam logic            POL_LOW  = (ACTIVE_LOW != 0);
    localparam logic [6:0]      BLANK    = seg_polarity(SEG_BLANK_AL, POL_LOW);

    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [PRE_W-1:0]        prescaler_reg;
    logic                    blink_phase_reg;
    logic [7*NUM_DIGITS-1:0] seg_reg;
    logic [7*NUM_DIGITS-1:0] seg_next;

    // upper_zero[i] = nibbles i..NUM_DIGITS-1 are all zero (OR-scan from the MSB digit).
    logic [NUM_DIGITS:0]     upper_zero;
    assign upper_zero[NUM_DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] nibble;
            logic [6:0] code;
            logic       lz_blank;
            logic       blink_blank;
            logic [6:0] digit_next;

            assign nibble = value_reg[4*gi +: 4];

            hex_seg_decode u_decode (
                .nibble (nibble),
                .code   (code)
            );

            assign upper_zero[gi] = upper_zero[gi+1] && (nibble == 4'h0);
            assign lz_blank       = blank_lz && upper_zero[gi] && (gi != 0);
            assign blink_blank    = blink_phase_reg && blink_mask[gi];

            assign digit_next = !enable     ? BLANK :
                                lz_blank    ? BLANK :
                                blink_blank ? BLANK :
                                seg_polarity(code, POL_LOW);

            assign seg_next[7*gi +: 7] = digit_next;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_reg       <= '0;
            prescaler_reg   <= '0;
            blink_phase_reg <= 1'b0;
            seg_reg         <= {NUM_DIGITS{BLANK}};
        end else begin
            seg_reg <= seg_next;
            // A load restarts the blink cycle so a fresh value is visible for a full half-period.
            if (load) begin
                value_reg       <= value;
                prescaler_reg   <= '0;
                blink_phase_reg <= 1'b0;
            end else if (prescaler_reg == PRE_LAST) begin
                prescaler_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                prescaler_reg   <= prescaler_reg + 1'b1;
            end
        end
    end

    assign seg = seg_reg;

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver: 4 digits, HALF = 4 cycles, active-low.
module tb_hex_display_driver;

    localparam int ND = 4;

    logic            clk;
    logic            resetn;
    logic            load;
    logic [4*ND-1:0] value;
    logic            blank_lz;
    logic [ND-1:0]   blink_mask;
    logic            enable;
    logic [7*ND-1:0] seg;

    hex_display_driver #(
        .NUM_DIGITS (ND),
        .CLK_HZ     (8),
        .BLINK_HZ   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .enable     (enable),
        .seg        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [4*ND-1:0] value;
        logic            lz;
        logic [ND-1:0]   mask;
        logic            en;
        logic [7*ND-1:0] exp;
    } vec_t;

    typedef struct {
        string           name;
        logic [7*ND-1:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [7*ND-1:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                              input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seg(input string name, input logic [7*ND-1:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty seg=%h", seg);
        end else begin
            e = sb_q.pop_front();
            if (seg !== e.exp) begin
                errors++;
                $display("FAIL %s seg=%h expected=%h", e.name, seg, e.exp);
            end else begin
                $display("ok   %s seg=%h", e.name, seg);
            end
        end
    endtask

    // Load strobe on one edge; value shows on the following edge.
    task automatic do_load(input logic [4*ND-1:0] v, input logic lz, input logic [ND-1:0] m,
                           input logic en);
        value      = v;
        blank_lz   = lz;
        blink_mask = m;
        enable     = en;
        load       = 1'b1;
        tick();
        load       = 1'b0;
        value      = '0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"ld_1E2F",    16'h1E2F, 1'b0, 4'h0, 1'b1, pack4(7'h79, 7'h06, 7'h24, 7'h0E)};
        vecs[1] = '{"lz_00A0",    16'h00A0, 1'b1, 4'h0, 1'b1, pack4(7'h7F, 7'h7F, 7'h08, 7'h40)};
        vecs[2] = '{"lz_0000",    16'h0000, 1'b1, 4'h0, 1'b1, pack4(7'h7F, 7'h7F, 7'h7F, 7'h40)};
        vecs[3] = '{"nolz_0000",  16'h0000, 1'b0, 4'h0, 1'b1, pack4(7'h40, 7'h40, 7'h40, 7'h40)};
        vecs[4] = '{"ld_FEDC",    16'hFEDC, 1'b0, 4'h0, 1'b1, pack4(7'h0E, 7'h06, 7'h21, 7'h46)};
        vecs[5] = '{"ld_89AB",    16'h89AB, 1'b0, 4'h0, 1'b1, pack4(7'h00, 7'h10, 7'h08, 7'h03)};
        vecs[6] = '{"lz_0567",    16'h0567, 1'b1, 4'h0, 1'b1, pack4(7'h7F, 7'h12, 7'h02, 7'h78)};
        vecs[7] = '{"lz_0100",    16'h0100, 1'b1, 4'h0, 1'b1, pack4(7'h7F, 7'h79, 7'h40, 7'h40)};
        vecs[8] = '{"lz_F000",    16'hF000, 1'b1, 4'h0, 1'b1, pack4(7'h0E, 7'h40, 7'h40, 7'h40)};
        vecs[9] = '{"ld_1234",    16'h1234, 1'b0, 4'h0, 1'b1, pack4(7'h79, 7'h24, 7'h30, 7'h19)};

        resetn     = 1'b0;
        load       = 1'b0;
        value      = '0;
        blank_lz   = 1'b0;
        blink_mask = '0;
        enable     = 1'b1;

        // Reset state, then first edge after release shows zeros.
        tick();
        tick();
        expect_seg("reset_blank", {ND{7'h7F}});
        check_pop();
        resetn = 1'b1;
        expect_seg("post_reset_zero", {ND{7'h40}});
        tick();
        check_pop();

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].value, vecs[i].lz, vecs[i].mask, vecs[i].en);
            expect_seg(vecs[i].name, vecs[i].exp);
            tick();
            check_pop();
        end

        // blank_lz sampled live: toggling it re-registers without a load.
        do_load(16'h0042, 1'b1, 4'h0, 1'b1);
        blank_lz = 1'b0;
        expect_seg("lz_live_off", pack4(7'h40, 7'h40, 7'h19, 7'h24));
        tick();
        check_pop();
        blank_lz = 1'b1;
        expect_seg("lz_live_on", pack4(7'h7F, 7'h7F, 7'h19, 7'h24));
        tick();
        check_pop();
        blank_lz = 1'b0;

        // Blink digit 0 with HALF=4: lit for 4 edges, then blank for 4.
        do_load(16'h1234, 1'b0, 4'b0001, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            logic lit;
            lit = (((k - 1) / 4) % 2) == 0;
            expect_seg($sformatf("blink_k%0d", k),
                       pack4(7'h79, 7'h24, 7'h30, lit ? 7'h19 : 7'h7F));
            tick();
            check_pop();
        end
        // Load during the blank half: the load edge still shows blank, then 4 lit edges.
        value = 16'h1235;
        load  = 1'b1;
        expect_seg("blink_load_edge", pack4(7'h79, 7'h24, 7'h30, 7'h7F));
        tick();
        check_pop();
        load  = 1'b0;
        value = '0;
        for (int j = 1; j <= 5; j++) begin
            expect_seg($sformatf("blink_reload_j%0d", j),
                       pack4(7'h79, 7'h24, 7'h30, (j <= 4) ? 7'h12 : 7'h7F));
            tick();
            check_pop();
        end

        // Mid-blink asynchronous reset: blank without an edge.
        #2;
        resetn = 1'b0;
        #1;
        expect_seg("async_reset_blank", {ND{7'h7F}});
        check_pop();
        blink_mask = '0;
        tick();
        resetn = 1'b1;
        expect_seg("async_reset_release", {ND{7'h40}});
        tick();
        check_pop();

        // Reset release with leading-zero blanking keeps only digit 0.
        #2;
        resetn   = 1'b0;
        blank_lz = 1'b1;
        tick();
        resetn = 1'b1;
        expect_seg("reset_release_lz", pack4(7'h7F, 7'h7F, 7'h7F, 7'h40));
        tick();
        check_pop();
        blank_lz = 1'b0;

        // Disabled display still latches the load.
        do_load(16'h5555, 1'b0, 4'h0, 1'b0);
        expect_seg("disabled_load", {ND{7'h7F}});
        tick();
        check_pop();
        enable = 1'b1;
        expect_seg("enable_after_load", {ND{7'h12}});
        tick();
        check_pop();

        // Value changes without load are ignored.
        value = 16'h9999;
        expect_seg("hold_no_load", {ND{7'h12}});
        tick();
        check_pop();

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover entries=%0d required=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
